regfile_sb: RTL and testbench

- Parametrised successor to the CPU register file: width and depth are parameters, and it has two combinational read ports, one debug read port and one write port.
- Adds asynchronous active-low clear of all entries and optional write-to-read bypass.
- Adds a per-register scoreboard of busy bits, so the pipelined CPU can detect pending writes (RAW hazards).
- Sits between decode (reads, issue marking) and write-back (writes, busy clear).

---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with two bypassable read ports, a debug read port,
// one write port and a per-entry busy scoreboard for RAW hazard detection.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy2,
   input  logic [ADDR_W-1:0] test_addr,
   output logic [DATA_W-1:0] test_data,
   input  logic              RegWre,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   cnt_d;
   logic              wr_en;

   assign wr_en = RegWre && !(ZERO_REG != 0 && waddr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   // An issue and a write-back to the same entry on one edge leave it busy:
   // the write retires an older producer while the new one is still in flight.
   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < DEPTH; k++) begin
         busy_d[k] = (issue_valid && issue_addr == ADDR_W'(k)) ||
                     (busy_q[k] && !(RegWre && waddr == ADDR_W'(k)));
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int k = 0; k < DEPTH; k++) cnt_d = cnt_d + (ADDR_W+1)'(busy_d[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         busy_q   <= busy_d;
         busy_cnt <= cnt_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      if (!rst_n || (ZERO_REG != 0 && a == '0)) return '0;
      else if (BYPASS != 0 && RegWre && waddr == a) return wdata;
      else return mem[a];
   endfunction

   // A forwarded write makes the data usable now, unless a newer producer
   // is being issued to the same entry in this cycle.
   function automatic logic read_busy(input logic [ADDR_W-1:0] a);
      if (ZERO_REG != 0 && a == '0) return 1'b0;
      else if (BYPASS != 0 && RegWre && waddr == a && !(issue_valid && issue_addr == a))
         return 1'b0;
      else return busy_q[a];
   endfunction

   assign rdata1    = read_port(raddr1);
   assign rdata2    = read_port(raddr2);
   assign busy1     = read_busy(raddr1);
   assign busy2     = read_busy(raddr2);
   assign test_data = mem[test_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table for the single-cycle behaviour
// plus hand-written saturation and reset sequences.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic [4:0]  raddr1, raddr2, test_addr, waddr, issue_addr;
   logic        RegWre, issue_valid;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata2, test_data;
   logic        busy1, busy2;
   logic [5:0]  busy_cnt;
   logic [31:0] nb_rdata1, nb_rdata2, nb_test_data;
   logic        nb_busy1, nb_busy2;
   logic [5:0]  nb_busy_cnt;

   int checks = 0;
   int errors = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
      .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
      .test_addr(test_addr), .test_data(test_data),
      .RegWre(RegWre), .waddr(waddr), .wdata(wdata),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .busy_cnt(busy_cnt)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .rst_n(rst_n),
      .raddr1(raddr1), .rdata1(nb_rdata1), .busy1(nb_busy1),
      .raddr2(raddr2), .rdata2(nb_rdata2), .busy2(nb_busy2),
      .test_addr(test_addr), .test_data(nb_test_data),
      .RegWre(RegWre), .waddr(waddr), .wdata(wdata),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .busy_cnt(nb_busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [4:0]  test_addr;
      logic        regwre;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        issue_valid;
      logic [4:0]  issue_addr;
      logic [31:0] e_rdata1;
      logic        e_busy1;
      logic [31:0] e_rdata2;
      logic        e_busy2;
      logic [31:0] e_test;
      logic [5:0]  e_cnt;
      logic [31:0] e_nb_rdata1;
      logic        e_nb_busy1;
   } vec_t;

   vec_t vecs [17];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      raddr1      = v.raddr1;
      raddr2      = v.raddr2;
      test_addr   = v.test_addr;
      RegWre      = v.regwre;
      waddr       = v.waddr;
      wdata       = v.wdata;
      issue_valid = v.issue_valid;
      issue_addr  = v.issue_addr;
   endtask

   task automatic idleInputs();
      RegWre      = 1'b0;
      waddr       = '0;
      wdata       = '0;
      issue_valid = 1'b0;
      issue_addr  = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Pre-edge expectations; each row sees the state left by the rows before it.
      //          ra1 ra2 ta we wa  wdata         iv ia  rdata1        b1 rdata2        b2 test          cnt nb_rdata1    nb_b1
      vecs[0]  = '{5,  3,  3, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0,  32'h0,        0};
      vecs[1]  = '{3,  0,  3, 1, 3, 32'h12345678, 0, 0,  32'h12345678, 0, 32'h0,        0, 32'h0,        0,  32'h0,        0};
      vecs[2]  = '{0,  3,  3, 1, 0, 32'hFFFFFFFF, 0, 0,  32'h0,        0, 32'h12345678, 0, 32'h12345678, 0,  32'h0,        0};
      vecs[3]  = '{0,  0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0,  32'h0,        0};
      vecs[4]  = '{7,  0,  7, 1, 7, 32'h11,       0, 0,  32'h11,       0, 32'h0,        0, 32'h0,        0,  32'h0,        0};
      vecs[5]  = '{7,  0,  7, 1, 7, 32'h22,       0, 0,  32'h22,       0, 32'h0,        0, 32'h11,       0,  32'h11,       0};
      vecs[6]  = '{9,  7,  7, 0, 0, 32'h0,        1, 9,  32'h0,        0, 32'h22,       0, 32'h22,       0,  32'h0,        0};
      vecs[7]  = '{9,  0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'h0,        0, 32'h0,        1,  32'h0,        1};
      vecs[8]  = '{9,  9,  9, 1, 9, 32'hAA,       0, 0,  32'hAA,       0, 32'hAA,       0, 32'h0,        1,  32'h0,        1};
      vecs[9]  = '{9,  0,  9, 0, 0, 32'h0,        0, 0,  32'hAA,       0, 32'h0,        0, 32'hAA,       0,  32'hAA,       0};
      vecs[10] = '{4,  0,  0, 0, 0, 32'h0,        1, 4,  32'h0,        0, 32'h0,        0, 32'h0,        0,  32'h0,        0};
      vecs[11] = '{4,  4,  4, 1, 4, 32'h44,       1, 4,  32'h44,       1, 32'h44,       1, 32'h0,        1,  32'h0,        1};
      vecs[12] = '{4,  0,  4, 0, 0, 32'h0,        0, 0,  32'h44,       1, 32'h0,        0, 32'h44,       1,  32'h44,       1};
      vecs[13] = '{0,  0,  0, 0, 0, 32'h0,        1, 0,  32'h0,        0, 32'h0,        0, 32'h0,        1,  32'h0,        0};
      vecs[14] = '{0,  4,  0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h44,       1, 32'h0,        1,  32'h0,        0};
      vecs[15] = '{4,  0,  4, 1, 4, 32'h55,       0, 0,  32'h55,       0, 32'h0,        0, 32'h44,       1,  32'h44,       1};
      vecs[16] = '{4,  0,  4, 0, 0, 32'h0,        0, 0,  32'h55,       0, 32'h0,        0, 32'h55,       0,  32'h55,       0};

      rst_n = 1'b0;
      raddr1 = '0; raddr2 = '0; test_addr = '0;
      idleInputs();
      #1;
      checkOutput("reset_cnt", 32'(busy_cnt), 32'h0);
      checkOutput("reset_rdata1", rdata1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e_rdata1);
         checkOutput($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_busy1));
         checkOutput($sformatf("v%0d_rdata2", i), rdata2, vecs[i].e_rdata2);
         checkOutput($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vecs[i].e_busy2));
         checkOutput($sformatf("v%0d_test", i), test_data, vecs[i].e_test);
         checkOutput($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(vecs[i].e_cnt));
         checkOutput($sformatf("v%0d_nb_rdata1", i), nb_rdata1, vecs[i].e_nb_rdata1);
         checkOutput($sformatf("v%0d_nb_busy1", i), 32'(nb_busy1), 32'(vecs[i].e_nb_busy1));
         @(negedge clk);
      end
      idleInputs();

      // Issue every entry including r0; only the 31 nonzero ones can become busy.
      for (int k = 0; k < 32; k++) begin
         issue_valid = 1'b1;
         issue_addr  = 5'(k);
         @(negedge clk);
      end
      idleInputs();
      raddr1 = 5'd0;
      raddr2 = 5'd31;
      #1;
      checkOutput("sat_cnt", 32'(busy_cnt), 32'd31);
      checkOutput("sat_busy_r0", 32'(busy1), 32'h0);
      checkOutput("sat_busy_r31", 32'(busy2), 32'h1);

      for (int k = 1; k < 32; k++) begin
         RegWre = 1'b1;
         waddr  = 5'(k);
         wdata  = 32'(k) * 32'h101;
         @(negedge clk);
      end
      idleInputs();
      raddr1    = 5'd17;
      raddr2    = 5'd31;
      test_addr = 5'd31;
      #1;
      checkOutput("drain_cnt", 32'(busy_cnt), 32'd0);
      checkOutput("drain_rdata1", rdata1, 32'h1111);
      checkOutput("drain_busy2", 32'(busy2), 32'h0);
      checkOutput("drain_test", test_data, 32'h1F1F);

      // Asynchronous reset pulse between edges, then release mid-operation.
      @(negedge clk);
      RegWre = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      issue_valid = 1'b1; issue_addr = 5'd6;
      @(negedge clk);
      idleInputs();
      raddr1 = 5'd5; raddr2 = 5'd6; test_addr = 5'd5;
      #1;
      checkOutput("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
      checkOutput("pre_rst_cnt", 32'(busy_cnt), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_rdata1", rdata1, 32'h0);
      checkOutput("rst_cnt", 32'(busy_cnt), 32'h0);
      checkOutput("rst_busy2", 32'(busy2), 32'h0);
      checkOutput("rst_test", test_data, 32'h0);
      RegWre = 1'b1; waddr = 5'd8; wdata = 32'h99;
      raddr2 = 5'd8;
      issue_valid = 1'b1; issue_addr = 5'd8;
      #1;
      checkOutput("rst_bypass_rdata2", rdata2, 32'h0);
      @(negedge clk);
      wdata = 32'h77;
      issue_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      idleInputs();
      test_addr = 5'd8;
      #1;
      checkOutput("release_test", test_data, 32'h77);
      checkOutput("release_cnt", 32'(busy_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
